// File: rtl/sseg_scan_mux.sv
// ============================================================================
//  Module   : sseg_scan_mux
//  Function : Four-digit common-anode 7-segment scanner with per-slot capture,
//             anti-ghosting blank interval and frame pulse.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sseg_scan_mux #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blank_in,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int             c_CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [c_CW-1:0] c_LAST  = c_CW'(REFRESH_DIV - 1);
   localparam logic [c_CW-1:0] c_BLANK = c_CW'(BLANK_CYCLES);
   localparam logic [6:0]     c_DARK  = 7'b1111111;

   logic [c_CW-1:0] r_cnt;
   logic [1:0]      r_slot;
   logic [3:0]      r_nib;
   logic            r_dpb;
   logic            r_blk;

   logic            w_wrap;
   logic            w_drive;
   logic [6:0]      w_dec;
   logic [3:0]      w_an;
   logic [6:0]      w_seg;
   logic            w_dp;

   assign w_wrap = (r_cnt == c_LAST);

   // Slot prescaler and slot index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_slot <= 2'd0;
      end else begin
         r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
         if (w_wrap) begin
            r_slot <= r_slot + 2'd1;
         end
      end
   end

   // Per-slot snapshot: inputs are frozen for the whole slot so a slot never tears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nib <= 4'd0;
         r_dpb <= 1'b0;
         r_blk <= 1'b1;
      end else if (r_cnt == '0) begin
         r_nib <= digits[{r_slot, 2'b00} +: 4];
         r_dpb <= dp_in[r_slot];
         r_blk <= blank_in[r_slot];
      end
   end

   always_comb begin
      w_dec = c_DARK;
      case (r_nib)
         4'd0:    w_dec = 7'b1000000;
         4'd1:    w_dec = 7'b1111001;
         4'd2:    w_dec = 7'b0100100;
         4'd3:    w_dec = 7'b0110000;
         4'd4:    w_dec = 7'b0011001;
         4'd5:    w_dec = 7'b0010010;
         4'd6:    w_dec = 7'b0000010;
         4'd7:    w_dec = 7'b1111000;
         4'd8:    w_dec = 7'b0000000;
         4'd9:    w_dec = 7'b0010000;
         default: w_dec = c_DARK;
      endcase
   end

   assign w_drive = (r_cnt >= c_BLANK) && !r_blk;

   always_comb begin
      w_an  = 4'b1111;
      w_seg = c_DARK;
      w_dp  = 1'b1;
      if (w_drive) begin
         w_an  = ~(4'b0001 << r_slot);
         w_seg = w_dec;
         w_dp  = ~r_dpb;
      end
   end

   // Pin registers; the tick lands on the first cycle of slot 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an         <= 4'b1111;
         seg        <= c_DARK;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         an         <= w_an;
         seg        <= w_seg;
         dp         <= w_dp;
         frame_tick <= w_wrap && (r_slot == 2'd3);
      end
   end

endmodule

`default_nettype wire

// File: doc/sseg_scan_mux.md
# sseg_scan_mux

Four-digit time-multiplexed driver for the board's common-anode 7-segment display. It takes four BCD digits, per-digit decimal-point requests and per-digit blank flags from the datapath. It scans them onto the shared `an`/`seg`/`dp` pins with a programmable refresh rate and an anti-ghosting blank interval. It sits between the counter/datapath logic and the display pins, replacing the fixed single-digit drive.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz per slot, 250 Hz frame at 100 MHz); must be ≥ 4.
- `BLANK_CYCLES`, 1000: cycles at the start of each slot with all anodes off; must satisfy 1 ≤ BLANK_CYCLES < REFRESH_DIV.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `digits`  in  16  BCD digits; digit3 = [15:12] (leftmost), digit0 = [3:0] (rightmost).
- `dp_in`  in  4  1 = light decimal point of digit i.
- `blank_in`  in  4  1 = digit i dark (segments, dp and anode all off).
- `an`  out  4  anode enables, active low; an[i] drives digit i.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active low.
- `dp`  out  1  decimal point, active low.
- `frame_tick`  out  1  one-cycle pulse at start of each full 4-slot frame.

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1 and wraps to 0. A wrap advances `slot` 0→1→2→3→0.
- When `cnt == 0`, the nibble, dp_in bit and blank_in bit for the current `slot` are captured into holding registers. Input changes mid-slot are ignored until the next slot start, so there is no tearing.
- Two phases per slot, decided from `cnt`:
  - BLANK: `cnt < BLANK_CYCLES`. All anodes high, seg = 7'b1111111, dp = 1.
  - DRIVE: `cnt ≥ BLANK_CYCLES`. `an` = all ones except bit `slot` low. `seg` = decode of held nibble. `dp` = ~held dp bit.
  - If the held blank bit is 1, DRIVE outputs are the same as BLANK.
- Decode (active low): 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000.
  - Codes 10–15 → 1111111 (dark), while the anode and dp still drive normally.
- `frame_tick` = 1 for exactly one cycle per frame, asserted on the cycle after `cnt` wraps with `slot` going 3→0.
- All outputs are registered; there is no combinational path from inputs to pins.

## Timing
- Reset values, held while rst_n = 0:
  - Outputs: an = 4'b1111, seg = 7'b1111111, dp = 1, frame_tick = 0.
  - Internal: cnt = 0, slot = 0, holding registers = 0 (blank bit = 1).
- Reset assertion mid-slot forces the outputs dark immediately, without waiting for a clock edge.
- After release: the first rising edge performs capture for slot 0 with cnt = 0.
  - Outputs stay dark for BLANK_CYCLES+1 cycles.
  - Slot 0 anode then goes low.
- Output latency: registered outputs lag the `cnt` decision by one cycle.
  - an goes low on the edge after `cnt` reaches BLANK_CYCLES.
  - an returns high on the edge after `cnt` wraps to 0.
  - Active window per slot = REFRESH_DIV − BLANK_CYCLES cycles.
- Frame period = 4 × REFRESH_DIV cycles. frame_tick spacing is exact, with no drift.
- Anode exclusivity: at most one an bit is low on any cycle, including across slot boundaries. There is at least one all-high cycle between different digits.
- Simultaneous change of `digits` on a capture cycle: the value present on that cycle's edge is captured.

## Test plan
Run with REFRESH_DIV = 8, BLANK_CYCLES = 2 unless noted.
- **Reset:** hold rst_n = 0 for 5 cycles with digits = 16'h1234.
  - Required: an = 1111, seg = 1111111, dp = 1, frame_tick = 0 throughout.
  - Assert rst_n low mid-DRIVE: an = 1111 before the next edge.
- **Scan order:** digits = 16'h1234, dp_in = 0, blank_in = 0.
  - Required: an sequence 1110 (seg 0011001), 1101 (0110000), 1011 (0100100), 0111 (1111001).
  - Each is low for 6 cycles, preceded by 2 dark cycles.
  - frame_tick pulses every 32 cycles.
- **Decode sweep:** drive digit0 through 0–15 across successive frames.
  - Required: seg matches the table for 0–9; seg = 1111111 for 10–15 while an[0] is still low.
- **Blank/dp:** blank_in = 4'b0100, dp_in = 4'b0010, digits = 16'h8888.
  - Required: digit2 slot keeps an = 1111 for its full slot.
  - Digit1 shows seg = 0000000 with dp = 0; the other slots have dp = 1.
- **Tear-free capture:** change digits from 16'h0000 to 16'h9999 at cnt = 4 of slot 1.
  - Required: slot 1 still shows 1000000 until its end; slot 2 shows 0010000.
- **Exclusivity/period:** with REFRESH_DIV = 100000, BLANK_CYCLES = 1000, check over 3 frames:
  - Popcount of ~an ≤ 1 every cycle.
  - frame_tick interval = 400000 cycles exactly.
